// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory initiator: splits each 32-bit access into two timed
// 16-bit transfers on a word-addressed SRAM and stalls the pipeline meanwhile.
module mem_sram_ctrl #(
   parameter logic [15:0] ADDR_OFFSET = 16'd1024,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [15:0] address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        ready,
   output logic        stall,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_wdata,
   input  logic [15:0] sram_rdata,
   output logic        sram_we_n
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOW  = 2'd1;
   localparam logic [1:0] HIGH = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

   logic [1:0]  state_r, state_s;
   logic [3:0]  count_r, count_s;
   logic        is_write_r, is_write_s;
   logic [13:0] word_r, word_s;
   logic [31:0] wdata_r, wdata_s;
   logic [15:0] low_r;
   logic [15:0] idx_s;
   logic        last_s;
   logic [17:0] addr_s;
   logic [15:0] wd_s;
   logic        we_n_s;

   assign idx_s  = address - ADDR_OFFSET;
   assign last_s = (count_r == LAST);
   assign stall  = (read | write) & ~ready;

   // Next-state, phase counter and transaction latch.
   always_comb begin
      state_s    = state_r;
      count_s    = count_r;
      is_write_s = is_write_r;
      word_s     = word_r;
      wdata_s    = wdata_r;
      case (state_r)
         IDLE: begin
            if (read | write) begin
               state_s    = LOW;
               count_s    = 4'd0;
               is_write_s = write;
               word_s     = idx_s[15:2];
               wdata_s    = writedata;
            end else begin
               state_s    = IDLE;
            end
         end
         LOW: begin
            if (last_s) begin
               state_s = HIGH;
               count_s = 4'd0;
            end else begin
               count_s = count_r + 4'd1;
            end
         end
         HIGH: begin
            if (last_s) begin
               state_s = DONE;
               count_s = 4'd0;
            end else begin
               count_s = count_r + 4'd1;
            end
         end
         DONE: begin
            state_s = IDLE;
            count_s = 4'd0;
         end
         default: begin
            state_s = IDLE;
            count_s = 4'd0;
         end
      endcase
   end

   // SRAM pin values for the upcoming cycle; the last count of a write phase is a hold cycle.
   always_comb begin
      addr_s = 18'd0;
      wd_s   = 16'd0;
      we_n_s = 1'b1;
      case (state_s)
         LOW: begin
            addr_s = {3'b000, word_s, 1'b0};
            wd_s   = is_write_s ? wdata_s[15:0] : 16'd0;
            we_n_s = ~(is_write_s & (count_s != LAST));
         end
         HIGH: begin
            addr_s = {3'b000, word_s, 1'b1};
            wd_s   = is_write_s ? wdata_s[31:16] : 16'd0;
            we_n_s = ~(is_write_s & (count_s != LAST));
         end
         default: begin
            addr_s = 18'd0;
            wd_s   = 16'd0;
            we_n_s = 1'b1;
         end
      endcase
   end

   // State, registered SRAM pins, ready pulse and load-data assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         count_r    <= 4'd0;
         is_write_r <= 1'b0;
         word_r     <= 14'd0;
         wdata_r    <= 32'd0;
         low_r      <= 16'd0;
         readdata   <= 32'd0;
         ready      <= 1'b0;
         sram_addr  <= 18'd0;
         sram_wdata <= 16'd0;
         sram_we_n  <= 1'b1;
      end else begin
         state_r    <= state_s;
         count_r    <= count_s;
         is_write_r <= is_write_s;
         word_r     <= word_s;
         wdata_r    <= wdata_s;
         ready      <= (state_s == DONE);
         sram_addr  <= addr_s;
         sram_wdata <= wd_s;
         sram_we_n  <= we_n_s;
         if ((state_r == LOW) && last_s && !is_write_r) begin
            low_r <= sram_rdata;
         end
         if ((state_r == HIGH) && last_s && !is_write_r) begin
            readdata <= {sram_rdata, low_r};
         end
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench: two controllers (2 and 3 wait cycles) on behavioural SRAMs,
// compared against a word-level memory model and the documented cycle timing.
module tb_mem_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd    [2];
   logic        wr    [2];
   logic [15:0] ad    [2];
   logic [31:0] wd    [2];
   logic [31:0] rdata [2];
   logic        rdy   [2];
   logic        stl   [2];
   logic [17:0] sa    [2];
   logic [15:0] swd   [2];
   logic [15:0] srd   [2];
   logic        wen   [2];

   bit   [15:0] mem [2][32768];
   bit   [15:0] mdl [2][32768];
   logic [31:0] exp_rd [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_sram_ctrl #(.ADDR_OFFSET(16'd1024), .WAIT_CYCLES(2)) dut_w2 (
      .clk(clk), .rst(rst), .read(rd[0]), .write(wr[0]), .address(ad[0]),
      .writedata(wd[0]), .readdata(rdata[0]), .ready(rdy[0]), .stall(stl[0]),
      .sram_addr(sa[0]), .sram_wdata(swd[0]), .sram_rdata(srd[0]), .sram_we_n(wen[0]));

   mem_sram_ctrl #(.ADDR_OFFSET(16'd1024), .WAIT_CYCLES(3)) dut_w3 (
      .clk(clk), .rst(rst), .read(rd[1]), .write(wr[1]), .address(ad[1]),
      .writedata(wd[1]), .readdata(rdata[1]), .ready(rdy[1]), .stall(stl[1]),
      .sram_addr(sa[1]), .sram_wdata(swd[1]), .sram_rdata(srd[1]), .sram_we_n(wen[1]));

   assign srd[0] = mem[0][sa[0][14:0]];
   assign srd[1] = mem[1][sa[1][14:0]];

   // Asynchronous-read SRAM, written on the clock edge while the strobe is low.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!wen[k]) mem[k][sa[k][14:0]] <= swd[k];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; that cycle is cycle 0 of the access.
   // hold: last cycle the request stays asserted (-1 = to the end); keep: leave it asserted afterwards.
   task automatic txn(input int k, input logic r, input logic w, input logic [15:0] a,
                      input logic [31:0] d, input int hold, input bit keep);
      int          wt = (k == 0) ? 2 : 3;
      logic [15:0] idx;
      int          hw;
      int          rdy_at = -1;
      int          nrdy = 0;
      int          wl = 0;
      int          bad_stall = 0;
      bit          held = 1'b1;
      idx = a - 16'd1024;
      hw  = int'(idx[15:2]) * 2;
      if (w) begin
         mdl[k][hw]     = d[15:0];
         mdl[k][hw + 1] = d[31:16];
      end else if (r) begin
         exp_rd[k] = {mdl[k][hw + 1], mdl[k][hw]};
      end
      rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
      for (int c = 0; c <= 2 * wt + 1; c++) begin
         #1;
         if (rdy[k]) begin nrdy++; rdy_at = c; end
         if (!wen[k]) wl++;
         if (stl[k] !== (held && (c != 2 * wt + 1))) bad_stall++;
         if (c == 1) check("addr_lo", 32'(sa[k]), 32'(hw));
         if (c == wt + 1) check("addr_hi", 32'(sa[k]), 32'(hw + 1));
         if (c == 2 * wt + 1) check("readdata", rdata[k], exp_rd[k]);
         if (c == hold) begin rd[k] = 1'b0; wr[k] = 1'b0; held = 1'b0; end
         @(negedge clk);
      end
      if (!keep) begin rd[k] = 1'b0; wr[k] = 1'b0; end
      check("ready_cycle", 32'(rdy_at), 32'(2 * wt + 1));
      check("ready_pulses", 32'(nrdy), 32'd1);
      check("we_low_cycles", 32'(wl), w ? 32'(2 * (wt - 1)) : 32'd0);
      check("stall_cycles_bad", 32'(bad_stall), 32'd0);
      check("mem_lo", 32'(mem[k][hw]), 32'(mdl[k][hw]));
      check("mem_hi", 32'(mem[k][hw + 1]), 32'(mdl[k][hw + 1]));
   endtask

   initial begin
      int nrdy;
      int wl;
      for (int k = 0; k < 2; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = 16'd0; wd[k] = 32'd0; exp_rd[k] = 32'd0;
      end

      // Reset held for two cycles.
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_ready", 32'(rdy[k]), 32'd0);
         check("rst_we_n", 32'(wen[k]), 32'd1);
         check("rst_readdata", rdata[k], 32'd0);
         check("rst_sram_addr", 32'(sa[k]), 32'd0);
         check("rst_stall", 32'(stl[k]), 32'd0);
      end
      @(negedge clk);

      // Directed accesses on the 2-wait controller.
      txn(0, 1'b0, 1'b1, 16'd1028, 32'hDEADBEEF, -1, 1'b0);
      check("store_hw2", 32'(mem[0][2]), 32'h0000BEEF);
      check("store_hw3", 32'(mem[0][3]), 32'h0000DEAD);
      txn(0, 1'b1, 1'b0, 16'd1028, 32'h0, -1, 1'b0);
      check("load_data", rdata[0], 32'hDEADBEEF);
      txn(0, 1'b0, 1'b1, 16'd1036, 32'h0BADCAFE, -1, 1'b0);
      check("load_kept_after_store", rdata[0], 32'hDEADBEEF);
      txn(0, 1'b1, 1'b1, 16'd1032, 32'h12345678, -1, 1'b0);
      check("rw_hw4", 32'(mem[0][4]), 32'h00005678);
      check("rw_hw5", 32'(mem[0][5]), 32'h00001234);
      txn(0, 1'b1, 1'b0, 16'd1032, 32'h0, 1, 1'b0);
      check("dropped_load", rdata[0], 32'h12345678);

      // Reset in cycle 2 of a store: only the low half reaches the SRAM.
      wr[0] = 1'b1; ad[0] = 16'd1040; wd[0] = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; wr[0] = 1'b0;
      #1;
      check("rstmid_we_n", 32'(wen[0]), 32'd1);
      check("rstmid_addr", 32'(sa[0]), 32'd0);
      nrdy = 0; wl = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (rdy[0]) nrdy++;
         if (!wen[0]) wl++;
      end
      check("rstmid_no_ready", 32'(nrdy), 32'd0);
      check("rstmid_no_strobe", 32'(wl), 32'd0);
      check("rstmid_hw8", 32'(mem[0][8]), 32'h0000F00D);
      check("rstmid_hw9", 32'(mem[0][9]), 32'h00000000);
      mdl[0][8] = 16'hF00D;
      exp_rd[0] = 32'd0;
      @(negedge clk);

      // 3-wait controller: wrapped address, store then load back to back.
      txn(1, 1'b0, 1'b1, 16'd1020, 32'hA5A55A5A, -1, 1'b1);
      txn(1, 1'b1, 1'b0, 16'd1020, 32'h0, -1, 1'b0);
      check("wrap_hw_lo", 32'(mem[1][16'h7FFE]), 32'h00005A5A);
      check("wrap_load", rdata[1], 32'hA5A55A5A);

      // Random traffic over a small address pool so reads hit earlier writes.
      for (int n = 0; n < 24; n++) begin
         int          k;
         int          op;
         logic [15:0] a;
         k  = int'($urandom_range(1, 0));
         op = int'($urandom_range(2, 0));
         a  = 16'd1024 + 16'($urandom_range(7, 0) * 4) + 16'($urandom_range(3, 0));
         txn(k, (op != 1), (op != 0), a, $urandom, -1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
